// File: rtl/decode_stage.sv
// decode_stage: single-entry pipeline register that decodes one instruction.
//   clk, reset                      : clock, synchronous active-high reset
//   ibus, in_valid / in_ready       : upstream instruction handshake
//   flush                           : drop the held and the offered instruction
//   out_valid / out_ready           : downstream handshake for the decoded result
//   ibus_q, SID, ImmID, CinID,
//   SWID, LWID, illegal             : registered instruction and decode fields
//   dec_count, ill_count            : accepted (wrapping) and illegal (saturating) counters
module decode_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 6,
  parameter int unsigned FNW   = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ibus,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ibus_q,
  output logic [2:0]       SID,
  output logic             ImmID,
  output logic             CinID,
  output logic             SWID,
  output logic             LWID,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  // Opcode and function codes, zero-extended when the fields are wider than 6 bits
  localparam logic [OPW-1:0] OP_R    = '0;
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_XORI = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b011110);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b011111);

  localparam logic [FNW-1:0] FN_ADD  = FNW'(6'b000011);
  localparam logic [FNW-1:0] FN_SUB  = FNW'(6'b000010);
  localparam logic [FNW-1:0] FN_XOR  = FNW'(6'b000001);
  localparam logic [FNW-1:0] FN_AND  = FNW'(6'b000111);
  localparam logic [FNW-1:0] FN_OR   = FNW'(6'b000100);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OPW-1:0] opcode;
  logic [FNW-1:0] funct;
  logic           accept;

  logic [2:0]       sid_c;
  logic             imm_c, cin_c, sw_c, lw_c, ill_c;

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] ibus_q_q,  ibus_q_d;
  logic [2:0]       sid_q,     sid_d;
  logic             imm_q,     imm_d;
  logic             cin_q,     cin_d;
  logic             sw_q,      sw_d;
  logic             lw_q,      lw_d;
  logic             ill_q,     ill_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  assign opcode   = ibus[WIDTH-1 -: OPW];
  assign funct    = ibus[FNW-1:0];
  // Ready depends only on the output side so flush never gates the upstream handshake
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Instruction decode table; anything unlisted is illegal with all controls cleared
  always_comb begin
    sid_c = 3'b000;
    imm_c = 1'b0;
    cin_c = 1'b0;
    sw_c  = 1'b0;
    lw_c  = 1'b0;
    ill_c = 1'b0;
    case (opcode)
      OP_ADDI: begin sid_c = 3'b010; imm_c = 1'b1; end
      OP_SUBI: begin sid_c = 3'b011; imm_c = 1'b1; cin_c = 1'b1; end
      OP_XORI: begin sid_c = 3'b000; imm_c = 1'b1; end
      OP_ANDI: begin sid_c = 3'b110; imm_c = 1'b1; end
      OP_ORI:  begin sid_c = 3'b100; imm_c = 1'b1; end
      OP_LW:   begin sid_c = 3'b101; imm_c = 1'b1; lw_c = 1'b1; end
      OP_SW:   begin sid_c = 3'b101; imm_c = 1'b1; sw_c = 1'b1; end
      OP_R: begin
        case (funct)
          FN_ADD:  sid_c = 3'b010;
          FN_SUB:  begin sid_c = 3'b011; cin_c = 1'b1; end
          FN_XOR:  sid_c = 3'b000;
          FN_AND:  sid_c = 3'b110;
          FN_OR:   sid_c = 3'b100;
          default: ill_c = 1'b1;
        endcase
      end
      default: ill_c = 1'b1;
    endcase
  end

  // Next-state: flush beats acceptance, acceptance beats a plain drain
  always_comb begin
    valid_d   = valid_q;
    ibus_q_d  = ibus_q_q;
    sid_d     = sid_q;
    imm_d     = imm_q;
    cin_d     = cin_q;
    sw_d      = sw_q;
    lw_d      = lw_q;
    ill_d     = ill_q;
    dec_cnt_d = dec_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      ibus_q_d  = ibus;
      sid_d     = sid_c;
      imm_d     = imm_c;
      cin_d     = cin_c;
      sw_d      = sw_c;
      lw_d      = lw_c;
      ill_d     = ill_c;
      dec_cnt_d = dec_cnt_q + CNT_W'(1);
      if (ill_c && (ill_cnt_q != CNT_MAX)) begin
        ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ibus_q_q  <= '0;
      sid_q     <= 3'b000;
      imm_q     <= 1'b0;
      cin_q     <= 1'b0;
      sw_q      <= 1'b0;
      lw_q      <= 1'b0;
      ill_q     <= 1'b0;
      dec_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ibus_q_q  <= ibus_q_d;
      sid_q     <= sid_d;
      imm_q     <= imm_d;
      cin_q     <= cin_d;
      sw_q      <= sw_d;
      lw_q      <= lw_d;
      ill_q     <= ill_d;
      dec_cnt_q <= dec_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign ibus_q    = ibus_q_q;
  assign SID       = sid_q;
  assign ImmID     = imm_q;
  assign CinID     = cin_q;
  assign SWID      = sw_q;
  assign LWID      = lw_q;
  assign illegal   = ill_q;
  assign dec_count = dec_cnt_q;
  assign ill_count = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random stimulus with a scoreboard queue and a separate monitor.
//   Two instances share the stimulus: default counters and 2-bit counters
//   (the latter exercises wrap of dec_count and saturation of ill_count).
module tb_decode_stage;

  typedef struct {
    logic [31:0] ib;
    logic [2:0]  sid;
    logic        imm, cin, sw, lw, ill;
    logic [15:0] dc, ic;
    logic [1:0]  dc2, ic2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] ibus;

  logic        in_ready, out_valid, imm, cin, sw, lw, ill;
  logic [31:0] ibus_q;
  logic [2:0]  sid;
  logic [15:0] dec_count, ill_count;

  logic        in_ready2, out_valid2, imm2, cin2, sw2, lw2, ill2;
  logic [31:0] ibus_q2;
  logic [2:0]  sid2;
  logic [1:0]  dec_count2, ill_count2;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  exp_t        q[$];
  bit          m_valid = 1'b0;
  bit          started = 1'b0;
  bit          rst_chk = 1'b0;
  int unsigned n_dec = 0;
  int unsigned n_ill = 0;

  // Decode tables: opcode/funct value with (SID, CinID, SWID, LWID)
  int itab_op [7] = '{3, 2, 1, 15, 12, 30, 31};
  int itab_sid[7] = '{2, 3, 0, 6, 4, 5, 5};
  int itab_cin[7] = '{0, 1, 0, 0, 0, 0, 0};
  int itab_sw [7] = '{0, 0, 0, 0, 0, 0, 1};
  int itab_lw [7] = '{0, 0, 0, 0, 0, 1, 0};
  int rtab_fn [5] = '{3, 2, 1, 7, 4};
  int rtab_sid[5] = '{2, 3, 0, 6, 4};
  int rtab_cin[5] = '{0, 1, 0, 0, 0};

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .ibus(ibus), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ibus_q(ibus_q),
    .SID(sid), .ImmID(imm), .CinID(cin), .SWID(sw), .LWID(lw), .illegal(ill),
    .dec_count(dec_count), .ill_count(ill_count)
  );

  decode_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .ibus(ibus), .in_valid(in_valid), .in_ready(in_ready2),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .ibus_q(ibus_q2),
    .SID(sid2), .ImmID(imm2), .CinID(cin2), .SWID(sw2), .LWID(lw2), .illegal(ill2),
    .dec_count(dec_count2), .ill_count(ill_count2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t decode_ref(input logic [31:0] ib);
    exp_t e;
    int op, fn;
    op = int'(ib[31:26]);
    fn = int'(ib[5:0]);
    e = '{ib: ib, sid: 3'd0, imm: 1'b0, cin: 1'b0, sw: 1'b0, lw: 1'b0, ill: 1'b1,
          dc: 16'd0, ic: 16'd0, dc2: 2'd0, ic2: 2'd0};
    for (int i = 0; i < 7; i++) begin
      if (op == itab_op[i]) begin
        e.sid = 3'(itab_sid[i]); e.cin = 1'(itab_cin[i]); e.imm = 1'b1;
        e.sw = 1'(itab_sw[i]); e.lw = 1'(itab_lw[i]); e.ill = 1'b0;
      end
    end
    if (op == 0) begin
      for (int i = 0; i < 5; i++) begin
        if (fn == rtab_fn[i]) begin
          e.sid = 3'(rtab_sid[i]); e.cin = 1'(rtab_cin[i]); e.ill = 1'b0;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] ib;
    int r;
    ib = $urandom();
    r  = int'($urandom_range(0, 9));
    if (r <= 6) begin
      ib[31:26] = 6'(itab_op[$urandom_range(0, 6)]);
    end else if (r == 7) begin
      ib[31:26] = 6'd0;
      ib[5:0]   = 6'(rtab_fn[$urandom_range(0, 4)]);
    end else if (r == 8) begin
      ib[31:26] = 6'd0;
    end
    return ib;
  endfunction

  // Apply the rules to the inputs that were present at the edge just taken
  task automatic model_step();
    exp_t e;
    rst_chk = reset;
    if (reset) begin
      m_valid = 1'b0; n_dec = 0; n_ill = 0; q.delete();
    end else if (flush) begin
      m_valid = 1'b0; q.delete();
    end else if (in_valid && (!m_valid || out_ready)) begin
      e = decode_ref(ibus);
      n_dec++;
      if (e.ill) n_ill++;
      e.dc  = 16'(n_dec);
      e.ic  = (n_ill > 65535) ? 16'hffff : 16'(n_ill);
      e.dc2 = 2'(n_dec % 4);
      e.ic2 = (n_ill > 3) ? 2'd3 : 2'(n_ill);
      q.push_back(e);
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    started = 1'b1;
  endtask

  // Monitor: handshake checks each cycle, payload checks whenever the DUT presents output
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("out_valid_c2", 64'(out_valid2), 64'(m_valid));
        if (rst_chk) begin
          chk("rst_ibus_q", 64'(ibus_q), 64'd0);
          chk("rst_fields", 64'({sid, imm, cin, sw, lw, ill}), 64'd0);
          chk("rst_counts", 64'({dec_count, ill_count, dec_count2, ill_count2}), 64'd0);
          chk("rst_in_ready", 64'(in_ready), 64'd1);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'd0);
          end else begin
            e = q[0];
            chk("ibus_q", 64'(ibus_q), 64'(e.ib));
            chk("SID", 64'(sid), 64'(e.sid));
            chk("Imm/Cin/SW/LW/ill", 64'({imm, cin, sw, lw, ill}),
                64'({e.imm, e.cin, e.sw, e.lw, e.ill}));
            chk("dec_count", 64'(dec_count), 64'(e.dc));
            chk("ill_count", 64'(ill_count), 64'(e.ic));
            chk("dec_count_w2", 64'(dec_count2), 64'(e.dc2));
            chk("ill_count_w2", 64'(ill_count2), 64'(e.ic2));
            if (out_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; ibus = '0;
    repeat (2) begin @(posedge clk); model_step(); #1; end
    // ADDI 0x0C000000 with downstream ready
    reset = 1'b0; ibus = 32'h0C00_0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); model_step(); #1;
    // Illegal opcode 111111, then R-type with funct 111111
    ibus = 32'hFC00_0000;
    @(posedge clk); model_step(); #1;
    ibus = 32'h0000_003F;
    @(posedge clk); model_step(); #1;
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      ibus      = gen_instr();
      @(posedge clk); model_step(); #1;
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); model_step(); #1; end
    @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
